// File: rtl/fb_pkg.sv
// Shared framebuffer constants and writer state type.
// Used by the pixel writer, the ROM source and the display reader.
package fb_pkg;

  localparam int FB_H_RES       = 1280;
  localparam int FB_V_RES       = 960;
  localparam int FB_SCALE_SHIFT = 4;
  localparam int FB_GRID_W      = 80;
  localparam int FB_GRID_H      = 60;
  localparam int FB_RAM_DW      = 6;
  localparam int FB_RAMLENGTH   = 2400;
  localparam int FB_X_W         = 11;
  localparam int FB_Y_W         = 10;
  localparam int FB_RGB_W       = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_READ,
    S_MERGE
  } fb_state_e;

endpackage

// File: rtl/fb_addr_map.sv
// Source coordinate to framebuffer word address and lane.
// Purely combinational; also flags coordinates outside the source frame.
module fb_addr_map
  import fb_pkg::*;
#(
  parameter int H_RES       = FB_H_RES,
  parameter int V_RES       = FB_V_RES,
  parameter int SCALE_SHIFT = FB_SCALE_SHIFT,
  parameter int GRID_W      = FB_GRID_W,
  parameter int GRID_H      = FB_GRID_H,
  parameter int X_W         = FB_X_W,
  parameter int Y_W         = FB_Y_W,
  parameter int ADDR_W      = 12
) (
  input  logic [X_W-1:0]    hpos_i,
  input  logic [Y_W-1:0]    vpos_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              lane_o,
  output logic              in_range_o
);

  localparam int IDX_W = $clog2(GRID_W * GRID_H);

  logic [IDX_W-1:0] col;
  logic [IDX_W-1:0] row;
  logic [IDX_W-1:0] idx;

  assign col = IDX_W'(hpos_i >> SCALE_SHIFT);
  assign row = IDX_W'(vpos_i >> SCALE_SHIFT);
  assign idx = row * IDX_W'(GRID_W) + col;

  // Two cells share a word; bit 0 picks the lane.
  assign addr_o = ADDR_W'(idx >> 1);
  assign lane_o = idx[0];

  assign in_range_o = (hpos_i < X_W'(H_RES))
                   && (vpos_i < Y_W'(V_RES));

endmodule

// File: rtl/fb_writer.sv
// Pops pixels from a FIFO and read-modify-writes them into
// a packed two-pixel-per-word framebuffer, four cycles per pixel.
module fb_writer
  import fb_pkg::*;
#(
  parameter int H_RES         = FB_H_RES,
  parameter int V_RES         = FB_V_RES,
  parameter int SCALE_SHIFT   = FB_SCALE_SHIFT,
  parameter int GRID_W        = FB_GRID_W,
  parameter int GRID_H        = FB_GRID_H,
  parameter int RAM_DATAWIDTH = FB_RAM_DW,
  parameter int RAMLENGTH     = FB_RAMLENGTH,
  parameter int X_WIRE_WIDTH  = FB_X_W,
  parameter int Y_WIRE_WIDTH  = FB_Y_W,
  localparam int ADDR_WIDTH   = $clog2(RAMLENGTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     fifoempty,
  input  logic [X_WIRE_WIDTH+Y_WIRE_WIDTH+2:0] fifo_rdata,
  output logic                     fifo_rd,
  output logic [ADDR_WIDTH-1:0]    ram_addr,
  input  logic [RAM_DATAWIDTH-1:0] ram_rdata,
  output logic [RAM_DATAWIDTH-1:0] ram_wdata,
  output logic                     ram_we,
  output logic                     drop,
  output logic                     frame_done
);

  localparam int TOTAL = GRID_W * GRID_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int FW    = X_WIRE_WIDTH + Y_WIRE_WIDTH + 3;
  localparam int CW    = FB_RGB_W;

  fb_state_e state_q, state_d;

  logic [X_WIRE_WIDTH-1:0]  hpos;
  logic [Y_WIRE_WIDTH-1:0]  vpos;
  logic [CW-1:0]            rgb_in;
  logic [ADDR_WIDTH-1:0]    map_addr;
  logic                     map_lane;
  logic                     map_ok;

  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     lane_q;
  logic [CW-1:0]            rgb_q;
  logic [RAM_DATAWIDTH-1:0] word_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic                     rst_q;

  logic [RAM_DATAWIDTH-1:0] merged;
  logic                     pop_c;
  logic                     we_c;
  logic                     drop_c;
  logic [ADDR_WIDTH-1:0]    addr_c;
  logic [RAM_DATAWIDTH-1:0] wdata_c;

  assign hpos   = fifo_rdata[FW-1 -: X_WIRE_WIDTH];
  assign vpos   = fifo_rdata[CW +: Y_WIRE_WIDTH];
  assign rgb_in = fifo_rdata[CW-1:0];

  fb_addr_map #(
    .H_RES      (H_RES),
    .V_RES      (V_RES),
    .SCALE_SHIFT(SCALE_SHIFT),
    .GRID_W     (GRID_W),
    .GRID_H     (GRID_H),
    .X_W        (X_WIRE_WIDTH),
    .Y_W        (Y_WIRE_WIDTH),
    .ADDR_W     (ADDR_WIDTH)
  ) u_map (
    .hpos_i    (hpos),
    .vpos_i    (vpos),
    .addr_o    (map_addr),
    .lane_o    (map_lane),
    .in_range_o(map_ok)
  );

  always_comb begin
    merged = word_q;
    if (lane_q) merged[CW +: CW] = rgb_q;
    else        merged[0 +: CW]  = rgb_q;
  end

  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    we_c    = 1'b0;
    drop_c  = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    unique case (state_q)
      S_IDLE: begin
        // rst_q keeps the first post-reset cycle quiet.
        if (enable && !fifoempty && !done_q && !rst_q) begin
          pop_c   = 1'b1;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (map_ok) begin
          addr_c  = map_addr;
          state_d = S_READ;
        end else begin
          drop_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        addr_c  = addr_q;
        state_d = S_MERGE;
      end
      S_MERGE: begin
        addr_c  = addr_q;
        we_c    = 1'b1;
        wdata_c = merged;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      pop_c   = 1'b0;
      we_c    = 1'b0;
      drop_c  = 1'b0;
      addr_c  = '0;
      wdata_c = '0;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (we_c) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(TOTAL - 1)) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      lane_q  <= 1'b0;
      rgb_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (state_q == S_LATCH) begin
        addr_q <= map_addr;
        lane_q <= map_lane;
        rgb_q  <= rgb_in;
      end
      if (state_q == S_READ) word_q <= ram_rdata;
    end
  end

  assign fifo_rd    = pop_c;
  assign ram_we     = we_c;
  assign drop       = drop_c;
  assign ram_addr   = addr_c;
  assign ram_wdata  = wdata_c;
  assign frame_done = done_q;

endmodule
